// File: rtl/compensation_buffer.sv
// Banked store of per-PE compensation weights: serial column-major fill, one column per read beat.
// COMP_BUF_PINGPONG_EN selects two banks (overlapped load/preload); undefined gives a single bank.
module compensation_buffer #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 3,
  parameter int unsigned CW_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [CW_W-1:0]          wr_data,
  input  logic                     wr_col_end,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [ROWS*CW_W-1:0]     rd_data,
  output logic [$clog2(COLS)-1:0]  rd_col,
  output logic                     rd_last
);

`ifdef COMP_BUF_PINGPONG_EN
  localparam int unsigned NumBanks = 2;
`else
  localparam int unsigned NumBanks = 1;
`endif
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW = $clog2(COLS);

  logic [CW_W-1:0]     mem_q [NumBanks][ROWS][COLS];
  logic [NumBanks-1:0] full_q, full_d;
  logic [RowW-1:0]     wrow_q;
  logic [ColW-1:0]     wcol_q, rcol_q;
  logic                wbank, rbank;
  logic                wr_acc, col_adv, tile_done, rd_hs, rd_done;

  assign wr_ready  = !full_q[wbank];
  assign rd_valid  = full_q[rbank];
  assign rd_col    = rcol_q;
  assign rd_last   = rd_valid && (rcol_q == ColW'(COLS - 1));
  assign wr_acc    = wr_valid && wr_ready;
  // A write on the last row with col_end set still advances only once.
  assign col_adv   = wr_ready && (wr_col_end || (wr_valid && (wrow_q == RowW'(ROWS - 1))));
  assign tile_done = col_adv && (wcol_q == ColW'(COLS - 1));
  assign rd_hs     = rd_valid && rd_ready;
  assign rd_done   = rd_hs && rd_last;

`ifdef COMP_BUF_PINGPONG_EN
  logic wbank_q, rbank_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
    end else begin
      if (tile_done) wbank_q <= !wbank_q;
      if (rd_done)   rbank_q <= !rbank_q;
    end
  end

  assign wbank = wbank_q;
  assign rbank = rbank_q;
`else
  assign wbank = 1'b0;
  assign rbank = 1'b0;
`endif

  // Completion and release never target the same bank: one needs it empty, the other full.
  always_comb begin
    full_d = full_q;
    if (tile_done) full_d[wbank] = 1'b1;
    if (rd_done)   full_d[rbank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= '0;
      wrow_q <= '0;
      wcol_q <= '0;
      rcol_q <= '0;
    end else begin
      full_q <= full_d;
      if (col_adv) begin
        wrow_q <= '0;
        wcol_q <= tile_done ? '0 : wcol_q + 1'b1;
      end else if (wr_acc) begin
        wrow_q <= wrow_q + 1'b1;
      end
      if (rd_hs) rcol_q <= rd_last ? '0 : rcol_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < int'(NumBanks); b++)
        for (int r = 0; r < int'(ROWS); r++)
          for (int c = 0; c < int'(COLS); c++)
            mem_q[b][r][c] <= '0;
    end else begin
      // Clearing on release keeps skipped entries of the next tile at zero.
      if (rd_done)
        for (int r = 0; r < int'(ROWS); r++)
          for (int c = 0; c < int'(COLS); c++)
            mem_q[rbank][r][c] <= '0;
      if (wr_acc) mem_q[wbank][wrow_q][wcol_q] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < int'(ROWS); r++)
      rd_data[r*CW_W +: CW_W] = mem_q[rbank][r][rcol_q];
  end

endmodule

// File: doc/compensation_buffer.md
# compensation_buffer

Parametrised, double-buffered store of per-PE compensation weights for a ROWS x COLS tile of the systolic array. A serial weight stream from the compensation extractor fills one bank column by column, while the other bank is read out one column per beat to the pre-load unit. Overlapping load and preload removes the stall between tiles. Each bank is zero-cleared when it is released, so skipped entries always read as zero.

## Interface
- ROWS, 8, array rows; number of weights per column and per read beat.
- COLS, 3, columns per tile; number of read beats per tile.
- CW_W, 3, compensation weight width in bits.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; clock clk.
- wr_valid  in  1  wr_data valid this cycle.
- wr_ready  out  1  buffer accepts a write or column skip this cycle.
- wr_data  in  CW_W  weight for the current (row, col) of the write bank.
- wr_col_end  in  1  close the current column; the remaining rows stay zero.
- rd_valid  out  1  read bank is full; rd_data is valid.
- rd_ready  in  1  pre-load unit consumes the current beat.
- rd_data  out  ROWS*CW_W  weights of column rd_col; row r is at bits [r*CW_W +: CW_W], row 0 at the LSB.
- rd_col  out  $clog2(COLS)  column index of the current beat.
- rd_last  out  1  current beat is column COLS-1.

## Operation
- Storage: 2 banks x ROWS x COLS x CW_W flops, plus a full flag per bank.
- Pointers:
  - write side: wbank, wrow, wcol;
  - read side: rbank, rcol.
- Write accept: wr_valid && wr_ready. Stores wr_data at [wbank][wrow][wcol].
- Column advance happens on any of:
  - an accepted write with wrow==ROWS-1 (auto-advance);
  - an accepted write with wr_col_end=1;
  - wr_col_end=1 with wr_valid=0 and wr_ready=1 (column skip).
- On column advance: wrow<=0 and wcol<=wcol+1. A write with wrow==ROWS-1 and wr_col_end=1 advances once only.
- Tile complete: a column advance from wcol==COLS-1. The bank is marked full, wcol<=0, and wbank toggles.
- wr_ready = !full[wbank].
- Read: rd_valid = full[rbank]. rd_data is a combinational mux of bank rbank, column rcol. A handshake is rd_valid && rd_ready.
- On a handshake, rcol increments. If rd_last, rcol<=0, full[rbank]<=0, every entry of rbank is cleared to 0, and rbank toggles.
- Read and write sides are independent. A tile completion and a bank release in the same cycle are both applied.
- Reset: all entries 0, all flags and pointers 0. Outputs after reset: wr_ready=1, rd_valid=0, rd_data=0, rd_col=0, rd_last=0.

## Timing
- Write-to-read latency: a tile completed at edge T gives rd_valid=1 in the cycle after T, when that bank is rbank.
- Release: wr_ready returns 1 in the cycle after the edge that accepts rd_last, when the write side was blocked on that bank.
- Throughput: 1 write per cycle and 1 read beat per cycle, sustained. A tile is ROWS*COLS writes versus COLS beats, so the write side is the bottleneck.
- rd_data, rd_col and rd_last stay stable while rd_valid && !rd_ready.
- Mid-operation rst discards both banks immediately; partial tiles are lost.
- A wr_col_end with wrow==0 and no data closes an all-zero column.

## Configuration
- COMP_BUF_PINGPONG_EN defined: two banks with overlapped load and preload, as described above.
- COMP_BUF_PINGPONG_EN undefined: a single bank, with wbank and rbank tied to 0.
  - wr_ready=0 from tile completion until the rd_last handshake.
  - No write is accepted while the bank is being read.
  - All other rules are unchanged.

## Test plan
- Default params; stream 24 writes with values (r*3+c)&7 and no col_end -> 3 beats; rd_col 0,1,2; rd_last only on beat 2; each row field matches its written value.
- Per column: 2 writes, then wr_col_end with wr_valid=0 -> rows 2..7 read 0 on every beat.
- Write two tiles back-to-back with rd_ready=0 -> wr_ready drops after tile 2. After the first rd_last handshake, wr_ready=1 one cycle later. Tile 2 data is then intact.
- Hold rd_ready=0 for 5 cycles with rd_valid=1 -> rd_data, rd_col and rd_last are constant; then stream reads and writes concurrently with no lost or duplicated beat.
- Assert rst mid-tile after 10 writes -> rd_valid=0, wr_ready=1, and the next full tile reads back only new data with zeros elsewhere.
- With COMP_BUF_PINGPONG_EN undefined, write during readout -> wr_ready=0 until one cycle after rd_last.
